// File: rtl/bus_host_arbiter_pkg.sv
// Shared types and helpers for the bus host arbiter: arbiter state encoding
// and the round-robin pick function used to choose the next host.
package bus_arb_pkg;

    // Arbiter control states: free to arbitrate, or holding a selection
    // until the downstream port grants it.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    // Largest supported host count; rr_pick works on vectors of this size.
    localparam int unsigned MaxHosts = 8;

    // Returns the index of the first set bit in req, searching upward from
    // ptr and wrapping. Callers zero-pad unused request bits, so wrapping at
    // bit 7 behaves the same as wrapping at the real host count. When no bit
    // is set the pointer itself is returned; callers qualify with |req.
    function automatic logic [2:0] rr_pick(input logic [MaxHosts-1:0] req,
                                           input logic [2:0]          ptr);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MaxHosts; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Bundle of the host-side and device-side bus signals around the arbiter.
// Signal suffixes are written from the arbiter's point of view; the slave
// modport is the arbiter, the master modport is the surrounding system.
interface bus_host_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    // Host side
    logic [NrHosts-1:0]                    host_req_i;
    logic [NrHosts-1:0]                    host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i;
    logic [NrHosts-1:0]                    host_we_i;
    logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i;
    logic [NrHosts-1:0]                    host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o;
    logic [NrHosts-1:0]                    host_err_o;

    // Device side
    logic                                  dev_req_o;
    logic                                  dev_gnt_i;
    logic [AddressWidth-1:0]               dev_addr_o;
    logic                                  dev_we_o;
    logic [DataWidth/8-1:0]                dev_be_o;
    logic [DataWidth-1:0]                  dev_wdata_o;
    logic                                  dev_rvalid_i;
    logic [DataWidth-1:0]                  dev_rdata_i;
    logic                                  dev_err_i;

    // Diagnostics
    logic                                  resp_unexpected_o;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output resp_unexpected_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  resp_unexpected_o
    );

endinterface

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of granted host IDs. Each entry is one request that has been
// accepted downstream and is still waiting for its response.
module bus_arb_id_fifo #(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_id,
    input  logic             pop,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_id
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    // Pointer advance with wrap at the last slot, so non-power-of-two
    // depths are handled.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign head_id = mem[rd_ptr];

    // Overflowing pushes and underflowing pops are ignored so the pointers
    // can never get out of step with the count.
    assign do_push = push && !full_o;
    assign do_pop  = pop && !empty_o;

    // Storage: written behind the head, so a push together with a pop never
    // disturbs the entry being popped.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one downstream simple-system bus device port
// between several hosts. Grants are combinational on the device grant, the
// granted host ID is queued, and responses are routed back in order.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bus_host_arbiter_if.slave bus
);

    localparam int IdxW = $clog2(NrHosts);

    arb_state_e              state_q;
    logic [IdxW-1:0]         rr_q;
    logic [IdxW-1:0]         sel_q;
    logic [IdxW-1:0]         sel;
    logic [IdxW-1:0]         mux_sel;
    logic                    any_req;
    logic                    req_out;
    logic                    grant;
    logic                    rsp_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [IdxW-1:0]         head_id;
    logic                    resp_unexpected_q;
    logic [AddressWidth-1:0] addr_sel;
    logic [DataWidth-1:0]    wdata_sel;

    // Host index after i, wrapping at the last host.
    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == IdxW'(NrHosts - 1)) ? '0 : i + IdxW'(1);
    endfunction

    // Round-robin candidate for this cycle, starting at the pointer.
    assign sel     = IdxW'(rr_pick(MaxHosts'(bus.host_req_i), 3'(rr_q)));
    assign any_req = |bus.host_req_i;

    // Request generation: free selection when idle, frozen selection while
    // waiting. Only the registered FIFO count gates the request, so a
    // response popping the FIFO frees a slot one cycle later.
    always_comb begin
        mux_sel = sel;
        req_out = 1'b0;
        if (state_q == ARB_WAIT) begin
            mux_sel = sel_q;
            req_out = bus.host_req_i[sel_q] && !fifo_full;
        end else begin
            req_out = any_req && !fifo_full;
        end
    end

    // Reset masks the handshake outputs while it is held.
    assign grant         = req_out && bus.dev_gnt_i && !rst_i;
    assign bus.dev_req_o = req_out && !rst_i;

    // Attributes of the selected host go straight through to the device.
    assign addr_sel        = bus.host_addr_i[mux_sel];
    assign wdata_sel       = bus.host_wdata_i[mux_sel];
    assign bus.dev_addr_o  = addr_sel;
    assign bus.dev_wdata_o = wdata_sel;
    assign bus.dev_we_o    = bus.host_we_i[mux_sel];
    assign bus.dev_be_o    = bus.host_be_i[mux_sel];

    // Grant back to exactly the host whose request was forwarded.
    always_comb begin
        bus.host_gnt_o = '0;
        if (grant) begin
            bus.host_gnt_o[mux_sel] = 1'b1;
        end
    end

    // A response belongs to the oldest outstanding request; with nothing
    // outstanding it is dropped and flagged one cycle later.
    assign rsp_pop = bus.dev_rvalid_i && !fifo_empty && !rst_i;

    // Response routing: valid and error go only to the owning host.
    always_comb begin
        bus.host_rvalid_o = '0;
        bus.host_err_o    = '0;
        if (rsp_pop) begin
            bus.host_rvalid_o[head_id] = 1'b1;
            bus.host_err_o[head_id]    = bus.dev_err_i;
        end
    end

    // Read data is shared by all hosts; only the owner sees rvalid.
    assign bus.host_rdata_o = {NrHosts{bus.dev_rdata_i}};

    // Arbitration state, round-robin pointer and frozen selection. A waiting
    // host that withdraws its request releases the selection rather than
    // blocking the port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant) begin
                        rr_q <= next_idx(sel);
                    end else if (req_out) begin
                        sel_q   <= sel;
                        state_q <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (grant) begin
                        rr_q    <= next_idx(sel_q);
                        state_q <= ARB_IDLE;
                    end else if (!bus.host_req_i[sel_q]) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // One-cycle flag for a response that arrived with nothing outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_unexpected_q <= 1'b0;
        end else begin
            resp_unexpected_q <= bus.dev_rvalid_i && fifo_empty;
        end
    end

    assign bus.resp_unexpected_o = resp_unexpected_q;

    bus_arb_id_fifo #(
        .Width (IdxW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (grant),
        .push_id (mux_sel),
        .pop     (rsp_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_id (head_id)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed scenarios followed by
// random traffic, compared against a transaction-level reference model
// through scoreboard queues.
module tb_bus_host_arbiter;

    localparam int NrHosts      = 2;
    localparam int DataWidth    = 32;
    localparam int AddressWidth = 32;
    localparam int MaxOut       = 2;

    typedef struct {
        int          host;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          host;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        unexp;
        logic        gnt;
        logic        rv;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    txn_t  outstanding[$];
    txn_t  gnt_q[$];
    resp_t resp_q[$];
    cyc_t  cyc_q[$];
    int    next_host;
    int    locked;
    int    drop_host;
    logic  unexp_next;

    // Free-running clock.
    always #5 clk = ~clk;

    bus_host_arbiter_if #(
        .NrHosts(NrHosts), .DataWidth(DataWidth), .AddressWidth(AddressWidth)
    ) bus ();

    bus_host_arbiter #(
        .NrHosts(NrHosts), .DataWidth(DataWidth),
        .AddressWidth(AddressWidth), .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One bus cycle: hosts update their requests, the device inputs are set,
    // and the reference model predicts this cycle's behaviour.
    task automatic applyStimulus(input logic [NrHosts-1:0] raise,
                                 input logic [31:0] fixed_addr,
                                 input logic gnt, input logic rv,
                                 input logic err, input logic [31:0] rdata);
        txn_t t;
        resp_t r;
        cyc_t c;
        int   cand;
        int   h;
        logic full;
        logic was_empty;
        logic exp_req;
        logic granted;
        @(posedge clk);
        #1;
        if (drop_host >= 0) begin
            bus.host_req_i[drop_host] = 1'b0;
            drop_host = -1;
        end
        for (int i = 0; i < NrHosts; i++) begin
            if (raise[i] && !bus.host_req_i[i]) begin
                bus.host_req_i[i]   = 1'b1;
                bus.host_addr_i[i]  = (fixed_addr != 0) ? fixed_addr
                                                        : ($urandom & 32'hFFFF_FFFC);
                bus.host_we_i[i]    = 1'($urandom);
                bus.host_be_i[i]    = 4'($urandom);
                bus.host_wdata_i[i] = $urandom;
            end
        end
        bus.dev_gnt_i    = gnt;
        bus.dev_rvalid_i = rv;
        bus.dev_err_i    = err;
        bus.dev_rdata_i  = rdata;

        full      = (outstanding.size() >= MaxOut);
        was_empty = (outstanding.size() == 0);
        cand      = -1;
        if (locked >= 0) begin
            cand = locked;
        end else begin
            for (int k = 0; k < NrHosts; k++) begin
                h = (next_host + k) % NrHosts;
                if (cand < 0 && bus.host_req_i[h]) cand = h;
            end
        end
        exp_req = (cand >= 0) && bus.host_req_i[cand] && !full;
        granted = exp_req && gnt;

        c.req   = exp_req;
        c.addr  = (cand >= 0) ? bus.host_addr_i[cand] : 32'h0;
        c.unexp = unexp_next;
        c.gnt   = granted;
        c.rv    = rv && !was_empty;
        cyc_q.push_back(c);

        unexp_next = rv && was_empty;
        if (rv && !was_empty) begin
            t       = outstanding.pop_front();
            r.host  = t.host;
            r.rdata = rdata;
            r.err   = err;
            resp_q.push_back(r);
        end
        if (granted) begin
            t.host  = cand;
            t.addr  = bus.host_addr_i[cand];
            t.we    = bus.host_we_i[cand];
            t.be    = bus.host_be_i[cand];
            t.wdata = bus.host_wdata_i[cand];
            gnt_q.push_back(t);
            outstanding.push_back(t);
            next_host = (cand + 1) % NrHosts;
            locked    = -1;
            drop_host = cand;
        end else if (exp_req && locked < 0) begin
            locked = cand;
        end
    endtask

    task automatic drainResponses();
        for (int n = 0; n < 20 && outstanding.size() > 0; n++) begin
            applyStimulus('0, 32'h0, 1'b0, 1'b1, 1'b0, $urandom);
        end
    endtask

    // Mid-run reset with the device trying to handshake: outputs must drop
    // immediately and the model forgets everything outstanding.
    task automatic applyReset();
        @(posedge clk);
        #1;
        if (drop_host >= 0) begin
            bus.host_req_i[drop_host] = 1'b0;
            drop_host = -1;
        end
        bus.dev_gnt_i    = 1'b1;
        bus.dev_rvalid_i = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("rst_dev_req", 64'(bus.dev_req_o), 64'h0);
        checkOutput("rst_host_gnt", 64'(bus.host_gnt_o), 64'h0);
        checkOutput("rst_host_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        checkOutput("rst_unexpected", 64'(bus.resp_unexpected_o), 64'h0);
        outstanding.delete();
        next_host  = 0;
        locked     = -1;
        unexp_next = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.dev_gnt_i    = 1'b0;
        bus.dev_rvalid_i = 1'b0;
    endtask

    // Monitor: per-cycle handshake expectations, plus grant and response
    // contents popped whenever the DUT presents them.
    always @(negedge clk) begin
        cyc_t  c;
        txn_t  g;
        resp_t r;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            checkOutput("dev_req", 64'(bus.dev_req_o), 64'(c.req));
            if (c.req) checkOutput("dev_addr", 64'(bus.dev_addr_o), 64'(c.addr));
            checkOutput("resp_unexpected", 64'(bus.resp_unexpected_o), 64'(c.unexp));
            checkOutput("grant_present", 64'(|bus.host_gnt_o), 64'(c.gnt));
            checkOutput("rvalid_present", 64'(|bus.host_rvalid_o), 64'(c.rv));
        end
        if (bus.host_gnt_o != '0) begin
            if (gnt_q.size() == 0) begin
                checkOutput("grant_unexpected", 64'(bus.host_gnt_o), 64'h0);
            end else begin
                g = gnt_q.pop_front();
                checkOutput("grant_host", 64'(bus.host_gnt_o), 64'(1 << g.host));
                checkOutput("grant_addr", 64'(bus.dev_addr_o), 64'(g.addr));
                checkOutput("grant_we", 64'(bus.dev_we_o), 64'(g.we));
                checkOutput("grant_be", 64'(bus.dev_be_o), 64'(g.be));
                checkOutput("grant_wdata", 64'(bus.dev_wdata_o), 64'(g.wdata));
            end
        end
        if (bus.host_rvalid_o != '0) begin
            if (resp_q.size() == 0) begin
                checkOutput("rvalid_unexpected", 64'(bus.host_rvalid_o), 64'h0);
            end else begin
                r = resp_q.pop_front();
                checkOutput("resp_host", 64'(bus.host_rvalid_o), 64'(1 << r.host));
                checkOutput("resp_rdata", 64'(bus.host_rdata_o[r.host]), 64'(r.rdata));
                checkOutput("resp_err", 64'(bus.host_err_o),
                            r.err ? 64'(1 << r.host) : 64'h0);
            end
        end
    end

    initial begin
        logic [NrHosts-1:0] rmask;
        logic               rg;
        logic               rr;
        next_host  = 0;
        locked     = -1;
        drop_host  = -1;
        unexp_next = 1'b0;
        rst = 1'b0;
        bus.host_req_i   = '0;
        bus.host_addr_i  = '0;
        bus.host_we_i    = '0;
        bus.host_be_i    = '0;
        bus.host_wdata_i = '0;
        bus.dev_gnt_i    = 1'b0;
        bus.dev_rvalid_i = 1'b0;
        bus.dev_rdata_i  = '0;
        bus.dev_err_i    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_dev_req", 64'(bus.dev_req_o), 64'h0);
        checkOutput("reset_host_gnt", 64'(bus.host_gnt_o), 64'h0);
        checkOutput("reset_host_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        checkOutput("reset_unexpected", 64'(bus.resp_unexpected_o), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single host read");
        applyStimulus(2'b01, 32'h0010_0000, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);

        $display("[TB] round robin with both hosts requesting");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(2'b11, 32'h0, 1'b1, (i > 0), 1'b0, $urandom);
        end
        drainResponses();
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);

        $display("[TB] held selection");
        applyStimulus(2'b10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b01, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drainResponses();

        $display("[TB] full tracking fifo");
        applyStimulus(2'b11, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b11, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b11, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drainResponses();
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drainResponses();

        $display("[TB] unexpected and error responses");
        applyStimulus(2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001);
        applyStimulus(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 32'hBAD0_0BAD);
        applyStimulus(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] reset with requests outstanding");
        applyStimulus(2'b10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b01, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b11, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyReset();
        applyStimulus(2'b11, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5555_AAAA);
        applyStimulus(2'b11, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        drainResponses();
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drainResponses();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rmask = NrHosts'($urandom);
            rg    = ($urandom % 3) != 0;
            rr    = (outstanding.size() > 0) ? 1'($urandom) : (($urandom % 8) == 0);
            applyStimulus(rmask, 32'h0, rg, rr, (($urandom % 4) == 0), $urandom);
        end
        applyStimulus('0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drainResponses();
        applyStimulus('0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        drainResponses();
        applyStimulus('0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        checkOutput("grant_queue_empty", 64'(gnt_q.size()), 64'h0);
        checkOutput("resp_queue_empty", 64'(resp_q.size()), 64'h0);
        checkOutput("cycle_queue_empty", 64'(cyc_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_host_arbiter.md
# bus_host_arbiter

- Round-robin arbiter that shares one downstream device port of the simple-system bus between `NrHosts` requesters, for example the Ibex data port plus a future DMA or debug host.
- Forwards at most one request per cycle and records the granted host ID in an in-order tracking FIFO.
- Routes each `dev_rvalid_i` response back to the host that issued the matching request.
- Sits between the hosts and `bus`, which sees it as a single host.

## Interface
- `NrHosts`, default 2: number of requesters, 2..8.
- `DataWidth`, default 32: data bus width.
- `AddressWidth`, default 32: address width.
- `MaxOutstanding`, default 2: depth of the tracking FIFO (granted requests with no response yet), 1..8.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `host_req_i`  in  NrHosts  per-host request, held until granted.
- `host_gnt_o`  out  NrHosts  per-host grant, one-hot or zero.
- `host_addr_i`  in  NrHosts×AddressWidth  per-host address.
- `host_we_i`  in  NrHosts  per-host write enable.
- `host_be_i`  in  NrHosts×DataWidth/8  per-host byte enables.
- `host_wdata_i`  in  NrHosts×DataWidth  per-host write data.
- `host_rvalid_o`  out  NrHosts  per-host response valid, one-hot or zero.
- `host_rdata_o`  out  NrHosts×DataWidth  response data, broadcast to all hosts.
- `host_err_o`  out  NrHosts  per-host response error.
- `dev_req_o`  out  1  downstream request.
- `dev_gnt_i`  in  1  downstream grant.
- `dev_addr_o`, `dev_we_o`, `dev_be_o`, `dev_wdata_o`  out  —  attributes of the selected host, muxed through.
- `dev_rvalid_i`  in  1  downstream response valid.
- `dev_rdata_i`  in  DataWidth  downstream response data.
- `dev_err_i`  in  1  downstream response error.
- `resp_unexpected_o`  out  1  registered one-cycle pulse: `dev_rvalid_i` arrived while no request was outstanding.

## Operation
- The state machine has two states, `ARB_IDLE` and `ARB_WAIT`, plus a round-robin pointer `rr_q` (log2 NrHosts bits).
- **`ARB_IDLE`:**
  - The selected host `sel` is the first host with `host_req_i` set, searching from `rr_q` upward and wrapping at `NrHosts-1` to 0.
  - `dev_req_o` = any request AND FIFO not full.
  - If `dev_gnt_i` is also set in the same cycle, the request is granted: `host_gnt_o[sel]`=1, `sel` is pushed into the FIFO, `rr_q` ← `sel+1` (mod NrHosts), and the state stays `ARB_IDLE`.
  - If `dev_req_o` is set without `dev_gnt_i`, the arbiter registers `sel_q` ← `sel` and moves to `ARB_WAIT`.
- **`ARB_WAIT`:**
  - The selection is frozen: `sel_q` drives the downstream mux and `dev_req_o` = `host_req_i[sel_q]`.
  - Other hosts are not considered, even if they raise a request meanwhile.
  - On `dev_gnt_i` the request is granted as in `ARB_IDLE` (using `sel_q`), and the state returns to `ARB_IDLE`.
- **Full FIFO:** when count == `MaxOutstanding`, `dev_req_o`=0 in either state and `ARB_WAIT` is held. A pop in the same cycle does not unblock the request until the next cycle; there is no combinational path from `dev_rvalid_i` to `dev_req_o`.
- **Responses:**
  - On `dev_rvalid_i`, the arbiter pops the FIFO head `h` and drives `host_rvalid_o[h]`=1 and `host_err_o[h]`=`dev_err_i`.
  - `host_rdata_o` = `dev_rdata_i`, combinational.
  - If the FIFO is empty when `dev_rvalid_i` arrives, the response is dropped and `resp_unexpected_o` pulses on the next cycle.
- **Simultaneous push and pop:** allowed; the count is unchanged. The push writes behind the current head.
- **Routing rule:** responses are strictly in order; the downstream port guarantees in-order completion.
- **No-request host:** a host with `host_req_i`=0 never receives a grant, and a host is never granted twice in one cycle.

## Timing
- Grant is combinational: `host_gnt_o` follows `dev_gnt_i` in the same cycle.
- Response is combinational: `host_rvalid_o` follows `dev_rvalid_i` in the same cycle.
- Arbitration latency: zero cycles in `ARB_IDLE`. The pointer, FIFO and state update on the rising `clk_i` edge after the grant.
- Fairness: with N hosts requesting continuously, each host is granted once every N grants.
- **Reset:**
  - `rst_i` high asynchronously clears `rr_q`, the FIFO pointers, count, `sel_q` and `resp_unexpected_o`, and sets the state to `ARB_IDLE`.
  - Reset forces `dev_req_o`, `host_gnt_o` and `host_rvalid_o` to 0 while asserted.
  - Reset mid-transaction discards outstanding IDs; late responses after reset raise `resp_unexpected_o`.

## Structure
- `bus_arb_pkg` holds `arb_state_e` (`ARB_IDLE`, `ARB_WAIT`) and the helper function `rr_pick(req, ptr)` returning the index.
- Sub-module `bus_arb_id_fifo`: synchronous FIFO of width log2 NrHosts and depth `MaxOutstanding`.
  - Ports: push, pop, `full_o`, `empty_o` and head data.
  - It shares `clk_i` and `rst_i` with the arbiter.

## Test plan
- **Single host:** host0 issues a read to `0x00100000` with `dev_gnt_i` tied high; response `0xDEADBEEF` after 1 cycle → `host_gnt_o`=`01`, `host_rvalid_o`=`01`, `host_rdata_o`=`0xDEADBEEF`.
- **Round-robin:** both hosts request continuously for 6 grants → grant order 0,1,0,1,0,1; each host's responses return to it in order.
- **Held selection:** host1 is selected and `dev_gnt_i` is low for 3 cycles while host0 raises a request → `dev_addr_o` stays at host1's address; host1 is granted first, then host0.
- **Full FIFO:** `MaxOutstanding`=2 with no responses → the third request sees `dev_req_o`=0. A response is popped while full → `dev_req_o` rises the cycle after the pop.
- **Unexpected response:** `dev_rvalid_i` with the FIFO empty → no `host_rvalid_o`, `resp_unexpected_o`=1 for exactly one cycle. An error response to host1 → `host_err_o`=`10`.
- **Reset:** `rst_i` pulsed with 2 requests outstanding → all outputs 0 immediately; after release, host0 is granted first.
